// File: rtl/icn2038s_rx_monitor_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// icn2038s_rx_monitor_if : panel-side pins plus decoded monitor outputs
// Rev 1.0
// ---------------------------------------------------------------------------
interface icn2038s_rx_monitor_if #(
  parameter int WIDTH = 16
);
  logic             sin;
  logic             sclk;
  logic             le;
  logic             oe;
  logic [4:0]       addr;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic             cmd_valid;
  logic [3:0]       cmd_code;
  logic [WIDTH-1:0] cmd_data;
  logic [4:0]       addr_out;
  logic             frame_err;
  logic             oe_active;

  modport master (
    output sin, sclk, le, oe, addr,
    input  data_out, data_valid, cmd_valid, cmd_code, cmd_data,
    input  addr_out, frame_err, oe_active
  );

  modport slave (
    input  sin, sclk, le, oe, addr,
    output data_out, data_valid, cmd_valid, cmd_code, cmd_data,
    output addr_out, frame_err, oe_active
  );
endinterface
`default_nettype wire

// File: rtl/icn2038s_rx_monitor.sv
`default_nettype none
// ---------------------------------------------------------------------------
// icn2038s_rx_monitor : decodes ICN2038S panel bus into data latches/commands
// Rev 1.0
// ---------------------------------------------------------------------------
module icn2038s_rx_monitor #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  wire logic            clk,
  input  wire logic            rst_n,
  icn2038s_rx_monitor_if.slave bus
);

  localparam logic [0:0] c_ST_SHIFT  = 1'b0;
  localparam logic [0:0] c_ST_LE_WIN = 1'b1;
  localparam logic [5:0] c_WIDTH_CNT = 6'(WIDTH);

  logic [SYNC_STAGES-1:0]      r_sin_sync;
  logic [SYNC_STAGES-1:0]      r_sclk_sync;
  logic [SYNC_STAGES-1:0]      r_le_sync;
  logic [SYNC_STAGES-1:0]      r_oen_sync;
  logic [SYNC_STAGES-1:0][4:0] r_addr_sync;

  logic w_sin_s, w_sclk_s, w_le_s;
  logic [4:0] w_addr_s;

  logic r_sin_d, r_sclk_d, r_le_d;
  logic r_sclk_rise, r_le_rise, r_le_fall;

  logic [0:0]       r_state, w_state_nxt;
  logic [WIDTH-1:0] r_shreg, w_shreg_nxt;
  logic [5:0]       r_bit_cnt, w_bit_cnt_nxt;
  logic [3:0]       r_le_cnt, w_le_cnt_nxt;
  logic             w_enter_win, w_classify, w_is_cmd, w_frame_bad;

  logic [WIDTH-1:0] r_data_out, r_cmd_data;
  logic             r_data_valid, r_cmd_valid, r_frame_err;
  logic [3:0]       r_cmd_code;
  logic [4:0]       r_addr_out;

  // oe is synchronized already inverted so the reset value reads as "outputs off"
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sin_sync  <= '0;
      r_sclk_sync <= '0;
      r_le_sync   <= '0;
      r_oen_sync  <= '0;
      r_addr_sync <= '0;
    end else begin
      r_sin_sync  <= {r_sin_sync[SYNC_STAGES-2:0], bus.sin};
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], bus.sclk};
      r_le_sync   <= {r_le_sync[SYNC_STAGES-2:0], bus.le};
      r_oen_sync  <= {r_oen_sync[SYNC_STAGES-2:0], ~bus.oe};
      r_addr_sync <= {r_addr_sync[SYNC_STAGES-2:0], bus.addr};
    end
  end

  assign w_sin_s  = r_sin_sync[SYNC_STAGES-1];
  assign w_sclk_s = r_sclk_sync[SYNC_STAGES-1];
  assign w_le_s   = r_le_sync[SYNC_STAGES-1];
  assign w_addr_s = r_addr_sync[SYNC_STAGES-1];

  // Registered edge strobes; sin is delayed alongside so the shifted bit matches the sclk edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sin_d     <= 1'b0;
      r_sclk_d    <= 1'b0;
      r_le_d      <= 1'b0;
      r_sclk_rise <= 1'b0;
      r_le_rise   <= 1'b0;
      r_le_fall   <= 1'b0;
    end else begin
      r_sin_d     <= w_sin_s;
      r_sclk_d    <= w_sclk_s;
      r_le_d      <= w_le_s;
      r_sclk_rise <= w_sclk_s & ~r_sclk_d;
      r_le_rise   <= w_le_s & ~r_le_d;
      r_le_fall   <= ~w_le_s & r_le_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= c_ST_SHIFT;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_SHIFT:  if (r_le_rise) w_state_nxt = c_ST_LE_WIN;
      c_ST_LE_WIN: if (r_le_fall) w_state_nxt = c_ST_SHIFT;
      default:     w_state_nxt = c_ST_SHIFT;
    endcase
  end

  always_comb begin
    w_enter_win = 1'b0;
    w_classify  = 1'b0;
    case (r_state)
      c_ST_SHIFT:  w_enter_win = r_le_rise;
      c_ST_LE_WIN: w_classify  = r_le_fall;
      default: ;
    endcase
  end

  // Counts include an sclk edge landing in the same cycle as the le fall
  always_comb begin
    w_shreg_nxt   = r_sclk_rise ? {r_shreg[WIDTH-2:0], r_sin_d} : r_shreg;
    w_bit_cnt_nxt = (r_sclk_rise && r_bit_cnt != 6'd63) ? r_bit_cnt + 6'd1 : r_bit_cnt;
    w_le_cnt_nxt  = r_le_cnt;
    if (r_state == c_ST_LE_WIN && r_sclk_rise && r_le_cnt != 4'd15)
      w_le_cnt_nxt = r_le_cnt + 4'd1;
    w_is_cmd    = (w_le_cnt_nxt >= 4'd3);
    w_frame_bad = ((w_bit_cnt_nxt - {2'b00, w_le_cnt_nxt}) != c_WIDTH_CNT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shreg      <= '0;
      r_bit_cnt    <= '0;
      r_le_cnt     <= '0;
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
      r_cmd_valid  <= 1'b0;
      r_cmd_code   <= '0;
      r_cmd_data   <= '0;
      r_addr_out   <= '0;
      r_frame_err  <= 1'b0;
    end else begin
      r_shreg      <= w_shreg_nxt;
      r_bit_cnt    <= w_classify ? 6'd0 : w_bit_cnt_nxt;
      r_le_cnt     <= w_enter_win ? 4'd0 : w_le_cnt_nxt;
      r_data_valid <= w_classify & ~w_is_cmd;
      r_cmd_valid  <= w_classify & w_is_cmd;
      if (w_classify) begin
        r_addr_out <= w_addr_s;
        if (w_is_cmd) begin
          r_cmd_code <= w_le_cnt_nxt;
          r_cmd_data <= w_shreg_nxt;
        end else begin
          r_data_out <= w_shreg_nxt;
          if (w_frame_bad) r_frame_err <= 1'b1;
        end
      end
    end
  end

  assign bus.data_out   = r_data_out;
  assign bus.data_valid = r_data_valid;
  assign bus.cmd_valid  = r_cmd_valid;
  assign bus.cmd_code   = r_cmd_code;
  assign bus.cmd_data   = r_cmd_data;
  assign bus.addr_out   = r_addr_out;
  assign bus.frame_err  = r_frame_err;
  assign bus.oe_active  = r_oen_sync[SYNC_STAGES-1];

endmodule
`default_nettype wire
